// File: rtl/rect_plotter_if.sv
// Pixel-writer bus for rect_plotter: rectangle request operands in, plot strobe and pixel out.
interface rect_plotter_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int S_W = 8,
    parameter int C_W = 3
);
    logic           start;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [S_W-1:0] w;
    logic [S_W-1:0] h;
    logic [C_W-1:0] colour_in;
    logic           mode;
    logic           stall;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;
    logic           busy;
    logic           done;

    modport master (
        output start, x0, y0, w, h, colour_in, mode, stall,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, colour_in, mode, stall,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/rect_plotter.sv
// Raster-scans a w x h rectangle one pixel per non-stalled cycle, filled or outline,
// emitting a plot strobe per visible pixel and a one-cycle done pulse at the end.
module rect_plotter #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int S_W = 8,
    parameter int C_W = 3
) (
    input  logic          clock,
    input  logic          resetn,
    rect_plotter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] x0_q, x0_d;
    logic [Y_W-1:0] y0_q, y0_d;
    logic [S_W-1:0] w_q, w_d;
    logic [S_W-1:0] h_q, h_d;
    logic [C_W-1:0] col_q, col_d;
    logic           mode_q, mode_d;
    logic [S_W-1:0] dx_q, dx_d;
    logic [S_W-1:0] dy_q, dy_d;

    logic last_col, last_row, on_edge, scanning;

    assign last_col = (dx_q == w_q - S_W'(1));
    assign last_row = (dy_q == h_q - S_W'(1));
    assign on_edge  = (dx_q == '0) || last_col || (dy_q == '0) || last_row;
    assign scanning = (state_q == SCAN);

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        mode_d  = mode_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d   = bus.x0;
                    y0_d   = bus.y0;
                    w_d    = bus.w;
                    h_d    = bus.h;
                    col_d  = bus.colour_in;
                    mode_d = bus.mode;
                    dx_d   = '0;
                    dy_d   = '0;
                    // A degenerate rectangle skips the scan but still reports completion.
                    state_d = (bus.w == '0 || bus.h == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                if (!bus.stall) begin
                    if (last_col) begin
                        dx_d = '0;
                        if (last_row) state_d = FINISH;
                        else          dy_d    = dy_q + S_W'(1);
                    end else begin
                        dx_d = dx_q + S_W'(1);
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            mode_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    // Outputs decode straight from cleared registers, so reset zeroes them without a clock.
    assign bus.x      = x0_q + X_W'(dx_q);
    assign bus.y      = y0_q + Y_W'(dy_q);
    assign bus.colour = col_q;
    assign bus.busy   = scanning;
    assign bus.done   = (state_q == FINISH);
    assign bus.plot   = scanning && !bus.stall && (!mode_q || on_edge);
endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: table of rectangles checked pixel by pixel,
// plus hand-written reset-abort and post-reset sequences.
module tb_rect_plotter;
    logic clock;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    rect_plotter_if #(.X_W(8), .Y_W(7), .S_W(8), .C_W(3)) bus ();

    rect_plotter #(.X_W(8), .Y_W(7), .S_W(8), .C_W(3)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] w;
        logic [7:0] h;
        logic       mode;
        logic [2:0] col;
        int         sf;     // first stalled cycle after accept (0 = none)
        int         sl;     // stall length
        logic       junk;   // hold start high with garbage operands during the scan
        int         e_scan;
        int         e_plot;
        int         e_done; // cycle (after accept) carrying the done pulse
        int         e_lx;   // last plotted x (999 = none)
        int         e_ly;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_rect(input vec_t v);
        int scans = 0, plots = 0, dones = 0, dcyc = -1, lx = 999, ly = 999;
        int dx, dy;
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ep;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.x0 = v.x0; bus.y0 = v.y0; bus.w = v.w; bus.h = v.h;
        bus.mode = v.mode; bus.colour_in = v.col; bus.stall = 1'b0;
        for (int cyc = 1; cyc <= 300 && dones == 0; cyc++) begin
            @(posedge clock); #1;
            bus.start = v.junk;
            bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
            bus.w = 8'($urandom); bus.h = 8'($urandom);
            bus.mode = 1'($urandom); bus.colour_in = 3'($urandom);
            bus.stall = (cyc >= v.sf && cyc < v.sf + v.sl);
            @(negedge clock);
            chk("busy_and_done", int'(bus.busy & bus.done), 0);
            if (bus.busy) begin
                dx = (v.w == 0) ? 0 : scans % int'(v.w);
                dy = (v.w == 0) ? 0 : scans / int'(v.w);
                ex = v.x0 + 8'(dx);
                ey = v.y0 + 7'(dy);
                ep = !bus.stall && (v.mode == 1'b0 || dx == 0 || dx == int'(v.w) - 1 ||
                                    dy == 0 || dy == int'(v.h) - 1);
                chk("pixel{x,y,plot,colour}", int'({bus.x, bus.y, bus.plot, bus.colour}),
                    int'({ex, ey, ep, v.col}));
                if (!bus.stall) begin
                    scans++;
                    if (bus.plot) begin
                        plots++;
                        lx = int'(bus.x);
                        ly = int'(bus.y);
                    end
                end
            end else begin
                chk("plot_outside_scan", int'(bus.plot), 0);
            end
            if (bus.done) begin
                dones++;
                dcyc = cyc;
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("scan_cycles", scans, v.e_scan);
        chk("plot_count", plots, v.e_plot);
        chk("done_cycle", dcyc, v.e_done);
        chk("done_pulses", dones, 1);
        chk("last_x", lx, v.e_lx);
        chk("last_y", ly, v.e_ly);
    endtask

    initial begin
        //          x0     y0    w     h     mode  col     sf sl junk  scan plot done lx   ly
        tbl[0] = '{8'd10, 7'd5, 8'd3, 8'd2, 1'b0, 3'b100, 0, 0, 1'b0, 6,  6,  7,  12,  6};
        tbl[1] = '{8'd20, 7'd10, 8'd4, 8'd3, 1'b1, 3'd2,  0, 0, 1'b1, 12, 10, 13, 23,  12};
        tbl[2] = '{8'd254, 7'd0, 8'd4, 8'd1, 1'b0, 3'd7,  0, 0, 1'b0, 4,  4,  5,  1,   0};
        tbl[3] = '{8'd3, 7'd3, 8'd0, 8'd5, 1'b0, 3'd1,    0, 0, 1'b0, 0,  0,  1,  999, 999};
        tbl[4] = '{8'd0, 7'd0, 8'd1, 8'd1, 1'b1, 3'd5,    0, 0, 1'b0, 1,  1,  2,  0,   0};
        tbl[5] = '{8'd5, 7'd126, 8'd2, 8'd3, 1'b0, 3'd3,  0, 0, 1'b0, 6,  6,  7,  6,   0};
        tbl[6] = '{8'd100, 7'd50, 8'd3, 8'd3, 1'b1, 3'd6, 0, 0, 1'b0, 9,  8,  10, 102, 52};
        tbl[7] = '{8'd7, 7'd7, 8'd4, 8'd0, 1'b0, 3'd2,    0, 0, 1'b0, 0,  0,  1,  999, 999};
        tbl[8] = '{8'd40, 7'd20, 8'd4, 8'd3, 1'b0, 3'd1,  6, 3, 1'b1, 12, 12, 16, 43,  22};

        resetn = 1'b0;
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        bus.mode = 1'b0; bus.colour_in = '0; bus.stall = 1'b0;
        #3;
        chk("reset_outputs", int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
        #9 resetn = 1'b1;

        foreach (tbl[i]) do_rect(tbl[i]);

        // Abort a 4x4 fill right after its second pixel.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.x0 = 8'd60; bus.y0 = 7'd30; bus.w = 8'd4; bus.h = 8'd4;
        bus.mode = 1'b0; bus.colour_in = 3'd2;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("second_pixel{x,y,plot}", int'({bus.x, bus.y, bus.plot}), int'({8'd61, 7'd30, 1'b1}));
        #1 resetn = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("after_abort{plot,busy,done}", int'({bus.plot, bus.busy, bus.done}), 0);
        end

        do_rect(tbl[0]);
        do_rect(tbl[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rect_plotter.md
RECT_PLOTTER -- requirements
Module: rect_plotter

Interface
REQ-001 SHALL have parameter X_W, default 8, meaning pixel x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, meaning pixel y-coordinate width.
REQ-003 SHALL have parameter S_W, default 8, meaning rectangle width/height field width.
REQ-004 SHALL have parameter C_W, default 3, meaning colour width.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1, meaning the asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a request to draw the rectangle described by the operand inputs.
REQ-008 SHALL have port x0, input, X_W, meaning the top-left x coordinate.
REQ-009 SHALL have port y0, input, Y_W, meaning the top-left y coordinate.
REQ-010 SHALL have port w, input, S_W, meaning the width in pixels.
REQ-011 SHALL have port h, input, S_W, meaning the height in pixels.
REQ-012 SHALL have port colour_in, input, C_W, meaning the pixel colour.
REQ-013 SHALL have port mode, input, 1, meaning 0 = filled and 1 = outline only.
REQ-014 SHALL have port stall, input, 1, meaning downstream not ready, so the scan holds.
REQ-015 SHALL have port x, output, X_W, meaning the current pixel x.
REQ-016 SHALL have port y, output, Y_W, meaning the current pixel y.
REQ-017 SHALL have port colour, output, C_W, meaning the current pixel colour.
REQ-018 SHALL have port plot, output, 1, meaning the write strobe for (x, y, colour).
REQ-019 SHALL have port busy, output, 1, meaning a rectangle is in progress.
REQ-020 SHALL have port done, output, 1, meaning a one-cycle completion pulse.

Function
REQ-021 SHALL implement FSM states IDLE, SCAN and FINISH.
REQ-022 In IDLE with start=1, SHALL latch x0, y0, w, h, colour_in and mode, and SHALL clear the offsets dx=dy=0.
REQ-023 On a start accepted with w=0 or h=0, SHALL go directly to FINISH without asserting plot.
REQ-024 On any other accepted start, SHALL go to SCAN, with busy=1 from the next cycle.
REQ-025 Each SCAN cycle with stall=0 SHALL present x=x0+dx and y=y0+dy, each truncated modulo 2^X_W and 2^Y_W respectively (wrap-around, no saturation), together with colour equal to the latched colour.
REQ-026 SHALL scan in raster order: dx increments; when dx=w-1, dx returns to 0 and dy increments.
REQ-027 In fill mode, SHALL assert plot=1 on every non-stalled SCAN cycle.
REQ-028 In outline mode, SHALL assert plot=1 only when dx=0, dx=w-1, dy=0 or dy=h-1; interior positions still consume one cycle each with plot=0.
REQ-029 SCAN SHALL last exactly w*h non-stalled cycles, so the first pixel appears one cycle after start is accepted.
REQ-030 When stall=1 in SCAN, SHALL force plot=0, hold dx, dy, x and y, and keep busy=1.
REQ-031 After the pixel at dx=w-1, dy=h-1 is presented, SHALL enter FINISH.
REQ-032 In FINISH, SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-033 SHALL ignore start while in SCAN or FINISH, with no effect on the latched operands.
REQ-034 SHALL allow a start in the cycle immediately after FINISH, giving back-to-back rectangles.
REQ-035 Operand inputs SHALL be don't-care outside the accepting cycle.

Reset
REQ-036 While resetn=0, SHALL immediately, regardless of clock, force state=IDLE, all of x, y, colour, plot, busy, done and dx, dy = 0, and clear the latched operands.
REQ-037 A reset during SCAN SHALL abort the rectangle, with no done pulse and no further plot.

Verification
REQ-038 Bench SHALL cover: x0=10, y0=5, w=3, h=2, fill, colour=3'b100 -> plot at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) on 6 consecutive cycles, then a done pulse.
REQ-039 Bench SHALL cover: w=4, h=3, outline -> 12 SCAN cycles, plot=1 on 10 of them, plot=0 at (1,1) and (2,1).
REQ-040 Bench SHALL cover: x0=254, w=4, h=1 -> x sequence 254, 255, 0, 1.
REQ-041 Bench SHALL cover: w=0, h=5 -> no plot, done pulse 1 cycle after start, busy never 1.
REQ-042 Bench SHALL cover: stall=1 for 3 cycles mid-scan -> plot=0 and x/y frozen, scan resumes at the same pixel, total pixels unchanged.
REQ-043 Bench SHALL cover: resetn=0 after the 2nd pixel of a 4x4 scan -> outputs 0 asynchronously, no done, and a new start is accepted normally afterwards.
